// File: rtl/adb_kbd_link.sv
// Bit-serial VIA shift-register link (CB1 clock / CB2 data) for the Mac Plus keyboard and Mac SE ADB models.
// Optional: define KBD_WAIT_TIMEOUT_EN to abandon a Plus command whose response never arrives.
module adb_kbd_link #(
  parameter int PLUS_DIV = 1300,
  parameter int SE_DIV   = 80
) (
  input  logic       clk32,
  input  logic       _systemReset,
  input  logic       clk8_en_p,
  input  logic       machineType,
  input  logic       cb2_o,
  input  logic       cb2_t,
  output logic       kbdclk,
  output logic       kbddata_o,
  input  logic [7:0] kbd_in_data,
  input  logic       kbd_in_strobe,
  output logic [7:0] kbd_out_data,
  output logic       kbd_out_strobe,
  input  logic       adb_listen,
  input  logic [7:0] adb_dout,
  input  logic       adb_dout_strobe,
  output logic [7:0] adb_din,
  output logic       adb_din_strobe,
  output logic       via_busy
);

  localparam int DIV_MAX = (PLUS_DIV > SE_DIV) ? PLUS_DIV : SE_DIV;
  localparam int CW      = $clog2(DIV_MAX + 1);
  localparam logic [CW-1:0] PLUS_DIV_W = CW'(PLUS_DIV);
  localparam logic [CW-1:0] SE_DIV_W   = CW'(SE_DIV);

  logic          kbdclk_q, kbdclk_d;
  logic          kbdclk_prev_q, kbdclk_prev_d;
  logic          kbddata_q, kbddata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    to_mac_q, to_mac_d;
  logic [7:0]    adb_din_q, adb_din_d;
  logic          out_stb_q, out_stb_d;
  logic          din_stb_q, din_stb_d;
  logic          tx_q, tx_d;
  logic          wait_q, wait_d;
  logic          rx_q, rx_d;
  logic          dv_q, dv_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          listen_prev_q, listen_prev_d;
`ifdef KBD_WAIT_TIMEOUT_EN
  logic [15:0]   wto_q, wto_d;
`endif

  logic          kbddat_i;
  logic          idle;
  logic          run;
  logic [CW-1:0] div;

  assign kbddat_i = ~cb2_t | cb2_o;
  assign idle     = ~tx_q & ~rx_q;
  assign run      = (tx_q & ~wait_q) | rx_q;
  assign div      = machineType ? SE_DIV_W : PLUS_DIV_W;

  // State register
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      kbdclk_q      <= 1'b1;
      kbdclk_prev_q <= 1'b1;
      kbddata_q     <= 1'b1;
      cnt_q         <= '0;
      shift_q       <= '0;
      to_mac_q      <= '0;
      adb_din_q     <= '0;
      out_stb_q     <= 1'b0;
      din_stb_q     <= 1'b0;
      tx_q          <= 1'b0;
      wait_q        <= 1'b0;
      rx_q          <= 1'b0;
      dv_q          <= 1'b0;
      bitcnt_q      <= '0;
      listen_prev_q <= 1'b0;
`ifdef KBD_WAIT_TIMEOUT_EN
      wto_q         <= '0;
`endif
    end else begin
      kbdclk_q      <= kbdclk_d;
      kbdclk_prev_q <= kbdclk_prev_d;
      kbddata_q     <= kbddata_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      to_mac_q      <= to_mac_d;
      adb_din_q     <= adb_din_d;
      out_stb_q     <= out_stb_d;
      din_stb_q     <= din_stb_d;
      tx_q          <= tx_d;
      wait_q        <= wait_d;
      rx_q          <= rx_d;
      dv_q          <= dv_d;
      bitcnt_q      <= bitcnt_d;
      listen_prev_q <= listen_prev_d;
`ifdef KBD_WAIT_TIMEOUT_EN
      wto_q         <= wto_d;
`endif
    end
  end

  // Next-state logic; later assignments take priority within a tick
  always_comb begin
    kbdclk_d      = kbdclk_q;
    kbdclk_prev_d = kbdclk_prev_q;
    kbddata_d     = kbddata_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    to_mac_d      = to_mac_q;
    adb_din_d     = adb_din_q;
    out_stb_d     = out_stb_q;
    din_stb_d     = din_stb_q;
    tx_d          = tx_q;
    wait_d        = wait_q;
    rx_d          = rx_q;
    dv_d          = dv_q;
    bitcnt_d      = bitcnt_q;
    listen_prev_d = listen_prev_q;
`ifdef KBD_WAIT_TIMEOUT_EN
    wto_d         = wto_q;
`endif
    if (clk8_en_p) begin
      out_stb_d = 1'b0;
      din_stb_d = 1'b0;

      if (run) begin
        if (cnt_q == div) begin
          cnt_d    = '0;
          kbdclk_d = ~kbdclk_q;
          // Falling edge: sample the Mac's bit, or present ours
          if (kbdclk_q) begin
            if (tx_q) shift_d = {shift_q[6:0], kbddat_i};
            if (rx_q) kbddata_d = to_mac_q[3'd7 - bitcnt_q];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d    = '0;
        kbdclk_d = 1'b1;
      end

      kbdclk_prev_d = kbdclk_q;

      if (!machineType) begin
        if (kbd_in_strobe) begin
          to_mac_d = kbd_in_data;
          dv_d     = 1'b1;
        end
        if (idle && !kbddat_i) begin
          tx_d     = 1'b1;
          bitcnt_d = '0;
        end
      end else begin
        if (idle) listen_prev_d = adb_listen;
        if (idle && adb_listen && !listen_prev_q) begin
          tx_d     = 1'b1;
          bitcnt_d = '0;
        end
        if (adb_dout_strobe) begin
          to_mac_d = adb_dout;
          rx_d     = 1'b1;
          bitcnt_d = '0;
        end
      end

`ifdef KBD_WAIT_TIMEOUT_EN
      if (wait_q) begin
        if (wto_q == 16'hFFFF) begin
          wto_d = '0;
          if (!(kbddat_i && dv_q)) begin
            wait_d = 1'b0;
            tx_d   = 1'b0;
            dv_d   = 1'b0;
          end
        end else begin
          wto_d = wto_q + 16'd1;
        end
      end else begin
        wto_d = '0;
      end
`endif

      // Mac released the line and a response is queued: turn the link around
      if (wait_q && kbddat_i && dv_q) begin
        wait_d = 1'b0;
        tx_d   = 1'b0;
        rx_d   = 1'b1;
      end

      if (!kbdclk_prev_q && kbdclk_q) begin
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          if (tx_q && !machineType) begin
            out_stb_d = 1'b1;
            wait_d    = 1'b1;
          end
          if (tx_q && machineType) begin
            adb_din_d = shift_q;
            din_stb_d = 1'b1;
            tx_d      = 1'b0;
          end
          if (rx_q) begin
            rx_d = 1'b0;
            dv_d = 1'b0;
          end
        end
      end
    end
  end

  // Outputs
  always_comb begin
    kbdclk         = kbdclk_q;
    kbddata_o      = kbddata_q;
    kbd_out_data   = shift_q;
    kbd_out_strobe = out_stb_q;
    adb_din        = adb_din_q;
    adb_din_strobe = din_stb_q;
    via_busy       = tx_q | rx_q;
  end

endmodule

// File: tb/tb_adb_kbd_link.sv
// Scoreboard bench for adb_kbd_link: random bytes, queued expectations, independent monitor.
module tb_adb_kbd_link;
  localparam int PLUS_DIV = 1300;
  localparam int SE_DIV   = 80;
  localparam int BUDGET   = 40000;

  logic       clk32 = 1'b0;
  logic       _systemReset = 1'b0;
  logic       clk8_en_p = 1'b1;
  logic       machineType = 1'b0;
  logic       cb2_o = 1'b1;
  logic       cb2_t = 1'b0;
  logic       kbdclk, kbddata_o;
  logic [7:0] kbd_in_data = '0;
  logic       kbd_in_strobe = 1'b0;
  logic [7:0] kbd_out_data;
  logic       kbd_out_strobe;
  logic       adb_listen = 1'b0;
  logic [7:0] adb_dout = '0;
  logic       adb_dout_strobe = 1'b0;
  logic [7:0] adb_din;
  logic       adb_din_strobe;
  logic       via_busy;

  adb_kbd_link #(.PLUS_DIV(PLUS_DIV), .SE_DIV(SE_DIV)) dut (
    .clk32(clk32), ._systemReset(_systemReset), .clk8_en_p(clk8_en_p),
    .machineType(machineType), .cb2_o(cb2_o), .cb2_t(cb2_t),
    .kbdclk(kbdclk), .kbddata_o(kbddata_o),
    .kbd_in_data(kbd_in_data), .kbd_in_strobe(kbd_in_strobe),
    .kbd_out_data(kbd_out_data), .kbd_out_strobe(kbd_out_strobe),
    .adb_listen(adb_listen), .adb_dout(adb_dout), .adb_dout_strobe(adb_dout_strobe),
    .adb_din(adb_din), .adb_din_strobe(adb_din_strobe), .via_busy(via_busy)
  );

  always #5 clk32 = ~clk32;

  // Enable changes just after the active edge; random density in SE phases
  int en_mode = 0;
  always @(posedge clk32) begin
    #1;
    clk8_en_p = (en_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] plus_q[$];
  logic [7:0] se_q[$];
  logic       bit_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic abort(input string what);
    n_chk++;
    $display("FAIL %s: timed out", what);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  // Returns number of enabled ticks spent before kbdclk reached lvl
  task automatic wait_kbdclk(input logic lvl, output int ticks);
    int cyc = 0;
    ticks = 0;
    while (kbdclk !== lvl && cyc < BUDGET) begin
      if (clk8_en_p) ticks++;
      @(negedge clk32);
      cyc++;
    end
    if (kbdclk !== lvl) abort("wait kbdclk");
  endtask

  task automatic wait_busy(input logic lvl);
    int cyc = 0;
    while (via_busy !== lvl && cyc < BUDGET) begin
      @(negedge clk32);
      cyc++;
    end
    if (via_busy !== lvl) abort("wait via_busy");
  endtask

  // A one on the line may be an undriven pin or a driven high
  task automatic set_line(input logic v);
    if (v) begin
      if ($urandom_range(0, 1) == 0) cb2_t = 1'b0;
      else begin cb2_t = 1'b1; cb2_o = 1'b1; end
    end else begin
      cb2_t = 1'b1; cb2_o = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int exp_half);
    int t;
    for (int i = 7; i >= 0; i--) begin
      set_line(b[i]);
      wait_kbdclk(1'b0, t);
      wait_kbdclk(1'b1, t);
      if (i == 7) check("half-period ticks", t, exp_half);
    end
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_q.push_back(b[i]);
  endtask

  task automatic pulse_kbd_in(input logic [7:0] d);
    kbd_in_data = d; kbd_in_strobe = 1'b1;
    do @(posedge clk32); while (!clk8_en_p);
    #1 kbd_in_strobe = 1'b0;
    @(negedge clk32);
  endtask

  task automatic pulse_adb_dout(input logic [7:0] d);
    adb_dout = d; adb_dout_strobe = 1'b1;
    do @(posedge clk32); while (!clk8_en_p);
    #1 adb_dout_strobe = 1'b0;
    @(negedge clk32);
  endtask

  // Monitor: a strobe is consumed on the one sample where the next edge is enabled
  logic prev_clk = 1'b1;
  always @(negedge clk32) begin
    if (_systemReset) begin
      if (kbd_out_strobe && clk8_en_p) begin
        if (plus_q.size() == 0) check("kbd_out_strobe spurious", kbd_out_strobe, 0);
        else begin
          check("kbd_out_data", kbd_out_data, plus_q.pop_front());
          check("kbdclk high at kbd_out_strobe", kbdclk, 1);
        end
      end
      if (adb_din_strobe && clk8_en_p) begin
        if (se_q.size() == 0) check("adb_din_strobe spurious", adb_din_strobe, 0);
        else check("adb_din", adb_din, se_q.pop_front());
      end
      if (prev_clk && !kbdclk && bit_q.size() != 0) begin
        check("kbddata_o bit", kbddata_o, bit_q.pop_front());
        check("via_busy while receiving", via_busy, 1);
      end
    end
    prev_clk = kbdclk;
  end

  initial begin
    logic [7:0] b;
    int act;

    repeat (3) @(negedge clk32);
    check("reset kbdclk", kbdclk, 1);
    check("reset kbddata_o", kbddata_o, 1);
    check("reset kbd_out_data", kbd_out_data, 0);
    check("reset adb_din", adb_din, 0);
    check("reset kbd_out_strobe", kbd_out_strobe, 0);
    check("reset adb_din_strobe", adb_din_strobe, 0);
    check("reset via_busy", via_busy, 0);
    _systemReset = 1'b1;

    // Undriven CB2 in both modes: nothing happens
    for (int m = 0; m < 2; m++) begin
      machineType = m[0];
      act = 0;
      repeat (1000) begin
        @(negedge clk32);
        if (kbdclk !== 1'b1 || via_busy !== 1'b0 || kbd_out_strobe || adb_din_strobe) act++;
      end
      check("idle activity cycles", act, 0);
    end

    // Plus command then response
    machineType = 1'b0; en_mode = 0;
    @(negedge clk32);
    plus_q.push_back(8'h10);
    set_line(1'b0);
    wait_busy(1'b1);
    send_bits(8'h10, PLUS_DIV + 1);
    repeat (50) @(negedge clk32);
    check("plus command delivered", plus_q.size(), 0);
    set_line(1'b1);
    repeat (3000) @(negedge clk32);
    check("kbdclk held awaiting response", kbdclk, 1);
    check("via_busy awaiting response", via_busy, 1);
    push_bits(8'h7B);
    pulse_kbd_in(8'h7B);
    wait_busy(1'b0);
    repeat (100) @(negedge clk32);
    check("plus response bits consumed", bit_q.size(), 0);
    check("plus idle after response", via_busy, 0);
    check("kbdclk idle after response", kbdclk, 1);

    // SE listen: Mac shifts bytes to the ADB model
    machineType = 1'b1; en_mode = 1;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      se_q.push_back(b);
      set_line(b[7]);
      adb_listen = 1'b1;
      wait_busy(1'b1);
      send_bits(b, SE_DIV + 1);
      wait_busy(1'b0);
      adb_listen = 1'b0;
      repeat (50) @(negedge clk32);
      check("se listen delivered", se_q.size(), 0);
    end

    // SE talk: ADB model bytes serialised to the Mac
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'h3C : 8'($urandom_range(0, 255));
      push_bits(b);
      pulse_adb_dout(b);
      check("se talk busy", via_busy, 1);
      wait_busy(1'b0);
      repeat (5) @(negedge clk32);
      check("se talk bits consumed", bit_q.size(), 0);
      check("se talk kbdclk idle", kbdclk, 1);
    end

    // Reset halfway through an SE listen
    begin
      int t;
      b = 8'($urandom_range(0, 255));
      set_line(b[7]);
      adb_listen = 1'b1;
      wait_busy(1'b1);
      for (int i = 7; i >= 4; i--) begin
        set_line(b[i]);
        wait_kbdclk(1'b0, t);
        wait_kbdclk(1'b1, t);
      end
      #2 _systemReset = 1'b0;
      #1;
      check("mid reset kbdclk", kbdclk, 1);
      check("mid reset via_busy", via_busy, 0);
      check("mid reset kbd_out_data", kbd_out_data, 0);
      check("mid reset adb_din", adb_din, 0);
      adb_listen = 1'b0;
      repeat (3) @(negedge clk32);
      _systemReset = 1'b1;
      act = 0;
      repeat (1500) begin
        @(negedge clk32);
        if (kbdclk !== 1'b1 || via_busy !== 1'b0) act++;
      end
      check("activity after mid reset", act, 0);
    end

    check("plus queue drained", plus_q.size(), 0);
    check("se queue drained", se_q.size(), 0);
    check("bit queue drained", bit_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adb_kbd_link.md
Name: adb_kbd_link

Overview:
- Bit-serial link between the VIA shift-register pins (CB1 clock, CB2 data) and the keyboard/ADB byte-level models in the Mac Plus/SE data controller.
- Generates the keyboard clock and shifts command bytes out of the Mac.
- Shifts response bytes into the Mac.
- Mac Plus mode: handshake with the PS/2 keyboard translator. Mac SE mode: handshake with the ADB device model.

Parameters:
PLUS_DIV, 1300, clk8_en_p ticks per kbdclk half-period minus one, Mac Plus mode
SE_DIV, 80, clk8_en_p ticks per kbdclk half-period minus one, Mac SE mode

Ports:
clk32  in  1  32.5 MHz system clock
_systemReset  in  1  reset, asynchronous, active-low
clk8_en_p  in  1  8 MHz clock enable; all state advances only when high
machineType  in  1  0 = Mac Plus, 1 = Mac SE
cb2_o  in  1  VIA CB2 output value
cb2_t  in  1  VIA CB2 output enable
kbdclk  out  1  keyboard clock to VIA CB1
kbddata_o  out  1  serial data to VIA CB2 input
kbd_in_data  in  8  response byte from keyboard model (Plus)
kbd_in_strobe  in  1  one-tick valid for kbd_in_data
kbd_out_data  out  8  command byte shifted in from Mac (Plus)
kbd_out_strobe  out  1  one-tick pulse, kbd_out_data complete
adb_listen  in  1  ADB model requests a byte from the VIA (SE)
adb_dout  in  8  byte from ADB model to Mac
adb_dout_strobe  in  1  one-tick valid for adb_dout
adb_din  out  8  byte received from Mac for ADB model
adb_din_strobe  out  1  one-tick pulse, adb_din valid
via_busy  out  1  transmitting OR receiving

Behaviour:
- Reset values:
  - kbdclk = 1, kbddata_o = 1.
  - kbd_out_data = 0, adb_din = 0.
  - Both strobe outputs = 0, via_busy = 0.
  - Internal state: transmitting = 0, wait_receiving = 0, receiving = 0, data_valid = 0, bitcnt = 0, clock counter = 0, listen_d = 0.
- Line value: kbddat_i = ~cb2_t | cb2_o. An undriven line reads 1.
- Clock generator (per clk8_en_p tick):
  - Runs when (transmitting AND NOT wait_receiving) OR receiving. Otherwise counter = 0 and kbdclk = 1.
  - While running, the counter increments. When it equals DIV (PLUS_DIV or SE_DIV, chosen by machineType), kbdclk toggles and the counter clears. Half-period is therefore DIV+1 ticks; first falling edge comes DIV+1 ticks after start.
  - At a toggle where kbdclk is currently 1 (i.e. a falling edge):
    - If transmitting: kbd_out_data <= {kbd_out_data[6:0], kbddat_i}. MSB first.
    - If receiving: kbddata_o <= to_mac[7-bitcnt].
- Control:
  - kbdclk_d is registered each tick.
  - Strobe outputs default to 0 each tick, so every strobe is a single tick wide.
  - Plus mode:
    - kbd_in_strobe loads to_mac and sets data_valid.
    - Idle (NOT transmitting, NOT receiving) and kbddat_i = 0: transmitting = 1, bitcnt = 0.
  - SE mode:
    - listen_d <= adb_listen, updated only while idle.
    - Rising edge of listen while idle: transmitting = 1, bitcnt = 0.
    - adb_dout_strobe loads to_mac, sets receiving = 1, bitcnt = 0.
  - Both modes: wait_receiving AND kbddat_i = 1 AND data_valid moves to receive: wait_receiving = 0, transmitting = 0, receiving = 1.
  - On each kbdclk rising edge (NOT kbdclk_d AND kbdclk): bitcnt increments, 3-bit wrap. When bitcnt was 7:
    - Transmitting, Plus: kbd_out_strobe = 1 and wait_receiving = 1. The clock stops high.
    - Transmitting, SE: adb_din <= shift register, adb_din_strobe = 1, transmitting = 0.
    - Receiving: receiving = 0, data_valid = 0.
- Simultaneous events: data strobes ignore the mode that does not own them. The rising-edge handler is evaluated last in program order, so its assignments win.
- Reset mid-transfer: everything returns to reset values immediately. No partial strobe is issued.

Optional Feature:
- Macro: KBD_WAIT_TIMEOUT_EN.
- Defined: a 16-bit tick counter runs while wait_receiving = 1. At 65535 ticks with no valid response it clears wait_receiving, transmitting and data_valid, returning to idle with kbdclk = 1.
- Not defined: wait_receiving persists until a response arrives or reset.

Test Plan:
- Plus command: machineType = 0; drive CB2 low to start, then present bits 0x10 MSB-first, sampled at each kbdclk fall.
  - kbdclk half-period is 1301 ticks.
  - After 8 rising edges: kbd_out_data = 0x10, kbd_out_strobe pulses 1 tick, kbdclk held 1.
- Plus response: after the command, pulse kbd_in_strobe with 0x7B, then release CB2 high.
  - receiving asserts.
  - kbddata_o shows 0,1,1,1,1,0,1,1 at successive falls.
  - via_busy drops after the 8th rise.
- SE listen: machineType = 1; raise adb_listen; CB2 shifts 0xA5.
  - Half-period is 81 ticks.
  - adb_din = 0xA5, adb_din_strobe pulses once, transmitting clears.
- SE talk: pulse adb_dout_strobe with 0x3C.
  - kbddata_o serialises 0x3C MSB-first.
  - via_busy = 1 throughout, then 0.
- Reset mid-transfer: assert _systemReset after 4 bits.
  - kbdclk = 1, via_busy = 0 asynchronously.
  - No strobe fires afterwards.
- Idle: CB2 undriven (cb2_t = 0) → kbdclk stays 1, no activity.
